// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, bus ACK levels
// and the position of the read/write flag in the address byte.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        ADDR       = 4'd1,
        ADDR_ACK   = 4'd2,
        IDX        = 4'd3,
        IDX_ACK    = 4'd4,
        WDATA      = 4'd5,
        WDATA_ACK  = 4'd6,
        RDATA      = 4'd7,
        RDATA_ACK  = 4'd8,
        WAIT_STOP  = 4'd9
    } i2c_state_e;

    localparam logic ACK    = 1'b0;
    localparam logic NACK   = 1'b1;
    localparam int   RW_BIT = 0;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one asynchronous bus line with single-clk
// rise/fall pulses decoded from the synchronised level.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchroniser chain plus one history flop; resets to the idle-bus level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NUM_REGS 8-bit registers: write = index byte then data
// bytes, read = data bytes from the auto-incrementing register pointer.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h55,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2,
    localparam int        IDX_W       = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic             wr_en,
    output logic [IDX_W-1:0] reg_idx,
    output logic [7:0]       wr_data,
    input  logic [7:0]       rd_data,
    output logic             busy
);

    logic scl_s, scl_rise_s, scl_fall_s;
    logic sda_s, sda_rise_s, sda_fall_s;
    logic start_s, stop_s;
    logic [7:0] rx_byte_s;

    i2c_state_e       state_q,   state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q,   shift_d;
    logic [7:0]       tx_q,      tx_d;
    logic             phase_q,   phase_d;
    logic             rw_q,      rw_d;
    logic             sda_oe_q,  sda_oe_d;
    logic             wr_en_q,   wr_en_d;
    logic [IDX_W-1:0] reg_idx_q, reg_idx_d;
    logic [7:0]       wr_data_q, wr_data_d;
    logic             busy_q,    busy_d;

    function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_REGS - 1)) begin
            return '0;
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clk(clk), .reset_n(reset_n), .d_i(scl_i),
        .level_o(scl_s), .rise_o(scl_rise_s), .fall_o(scl_fall_s)
    );

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clk(clk), .reset_n(reset_n), .d_i(sda_i),
        .level_o(sda_s), .rise_o(sda_rise_s), .fall_o(sda_fall_s)
    );

    assign start_s   = sda_fall_s & scl_s;
    assign stop_s    = sda_rise_s & scl_s;
    assign rx_byte_s = {shift_q[6:0], sda_s};

    // Next-state logic: START beats STOP beats any bit-level activity.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        phase_d   = phase_q;
        rw_d      = rw_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        reg_idx_d = reg_idx_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (start_s) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            phase_d   = 1'b0;
            sda_oe_d  = 1'b0;
        end else if (stop_s) begin
            state_d  = IDLE;
            phase_d  = 1'b0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ADDR, IDX, WDATA: begin
                    if (scl_rise_s) begin
                        shift_d   = rx_byte_s;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ADDR: begin
                                    if (rx_byte_s[7:1] == TARGET_ADDR) begin
                                        state_d = ADDR_ACK;
                                        busy_d  = 1'b1;
                                        rw_d    = rx_byte_s[RW_BIT];
                                    end else begin
                                        state_d = WAIT_STOP;
                                    end
                                end
                                IDX: begin
                                    if ({1'b0, rx_byte_s} < 9'(NUM_REGS)) begin
                                        state_d   = IDX_ACK;
                                        reg_idx_d = rx_byte_s[IDX_W-1:0];
                                    end else begin
                                        state_d = WAIT_STOP;
                                    end
                                end
                                default: begin
                                    state_d   = WDATA_ACK;
                                    wr_en_d   = 1'b1;
                                    wr_data_d = rx_byte_s;
                                end
                            endcase
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end
                // First falling edge starts the ACK bit, the second one ends it.
                ADDR_ACK, IDX_ACK, WDATA_ACK: begin
                    if (scl_fall_s && !phase_q) begin
                        sda_oe_d = ~ACK;
                        phase_d  = 1'b1;
                    end else if (scl_fall_s) begin
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = 1'b0;
                        if (state_q == ADDR_ACK && rw_q) begin
                            state_d  = RDATA;
                            sda_oe_d = ~rd_data[7];
                            tx_d     = {rd_data[6:0], 1'b0};
                        end else if (state_q == WDATA_ACK) begin
                            state_d   = WDATA;
                            reg_idx_d = idx_next(reg_idx_q);
                        end else begin
                            state_d = (state_q == ADDR_ACK) ? IDX : WDATA;
                        end
                    end else begin
                        phase_d = phase_q;
                    end
                end
                RDATA: begin
                    if (scl_fall_s) begin
                        sda_oe_d = ~tx_q[7];
                        tx_d     = {tx_q[6:0], 1'b0};
                    end else if (scl_rise_s) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        phase_d   = 1'b0;
                        state_d   = (bit_cnt_q == 3'd7) ? RDATA_ACK : RDATA;
                    end else begin
                        tx_d = tx_q;
                    end
                end
                // Pointer moves on the master ACK so rd_data is ready for the next load.
                RDATA_ACK: begin
                    if (scl_fall_s && !phase_q) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_fall_s) begin
                        state_d   = RDATA;
                        phase_d   = 1'b0;
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = ~rd_data[7];
                        tx_d      = {rd_data[6:0], 1'b0};
                    end else if (scl_rise_s && !phase_q) begin
                        if (sda_s == ACK) begin
                            reg_idx_d = idx_next(reg_idx_q);
                            phase_d   = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else begin
                        phase_d = phase_q;
                    end
                end
                IDLE, WAIT_STOP: begin
                    state_d = state_q;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            tx_q      <= 8'h00;
            phase_q   <= 1'b0;
            rw_q      <= 1'b0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            reg_idx_q <= '0;
            wr_data_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            phase_q   <= phase_d;
            rw_q      <= rw_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            reg_idx_q <= reg_idx_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign wr_en   = wr_en_q;
    assign reg_idx = reg_idx_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Scoreboard bench: a bit-banged I2C master queues expected ACKs, read bytes
// and register writes; a monitor compares them as the DUT produces them.
module tb_i2c_target_regs;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       scl_m;
    logic       sda_m;
    logic       sda_i;
    logic       sda_oe;
    logic       wr_en;
    logic [3:0] reg_idx;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic [7:0] regs [16];

    int total = 0;
    int bad   = 0;

    logic [15:0] exp_wr  [$];
    logic        exp_ack [$];
    logic [7:0]  exp_rd  [$];
    logic        obs_ack [$];
    logic [7:0]  obs_rd  [$];

    always #5 clk = ~clk;

    assign sda_i   = sda_m & ~sda_oe;
    assign rd_data = regs[reg_idx];

    i2c_target_regs #(.TARGET_ADDR(7'h55), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n), .scl_i(scl_m), .sda_i(sda_i),
        .sda_oe(sda_oe), .wr_en(wr_en), .reg_idx(reg_idx), .wr_data(wr_data),
        .rd_data(rd_data), .busy(busy)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: register writes, ACK bits and read bytes against the queues.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got idx=%0d data=%0h expected none", reg_idx, wr_data);
            end else begin
                chk("wr_idx_data", {4'h0, reg_idx, wr_data}, exp_wr.pop_front());
            end
            regs[reg_idx] = wr_data;
        end
        if (obs_ack.size() > 0) begin
            if (exp_ack.size() == 0) begin
                total++; bad++;
                $display("FAIL ack_unexpected: got %0b expected none", obs_ack.pop_front());
            end else begin
                chk("ack_bit", 16'(obs_ack.pop_front()), 16'(exp_ack.pop_front()));
            end
        end
        if (obs_rd.size() > 0) begin
            if (exp_rd.size() == 0) begin
                total++; bad++;
                $display("FAIL rd_unexpected: got %0h expected none", obs_rd.pop_front());
            end else begin
                chk("rd_byte", 16'(obs_rd.pop_front()), 16'(exp_rd.pop_front()));
            end
        end
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wq(Q);
        scl_m = 1'b1; wq(2 * Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        b = sda_i;    wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_a);
        logic a;
        exp_ack.push_back(exp_a);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(a);
        obs_ack.push_back(a);
    endtask

    task automatic read_byte(input logic [7:0] exp_d, input logic mack);
        logic [7:0] d;
        logic       b;
        exp_rd.push_back(exp_d);
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        obs_rd.push_back(d);
        send_bit(mack);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic b;
        for (int i = 0; i < 16; i++) regs[i] = 8'h40 + 8'(i);
        reset_n = 1'b0;
        scl_m   = 1'b1;
        sda_m   = 1'b1;
        wq(3);
        chk("rst_sda_oe",  16'(sda_oe),  16'h0);
        chk("rst_busy",    16'(busy),    16'h0);
        chk("rst_wr_en",   16'(wr_en),   16'h0);
        chk("rst_reg_idx", 16'(reg_idx), 16'h0);
        chk("rst_wr_data", 16'(wr_data), 16'h0);
        reset_n = 1'b1;
        wq(5);

        // Write two bytes starting at index 3.
        exp_wr.push_back({8'd3, 8'h11});
        exp_wr.push_back({8'd4, 8'h22});
        i2c_start();
        write_byte(8'hAA, 1'b0);
        chk("wr_busy_set", 16'(busy), 16'h1);
        write_byte(8'h03, 1'b0);
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        i2c_stop();
        chk("wr_busy_clr", 16'(busy), 16'h0);
        chk("wr_idx_after", 16'(reg_idx), 16'h5);

        // Set index 5, repeated START, read three bytes.
        i2c_start();
        write_byte(8'hAA, 1'b0);
        write_byte(8'h05, 1'b0);
        i2c_start();
        write_byte(8'hAB, 1'b0);
        read_byte(8'h45, 1'b0);
        read_byte(8'h46, 1'b0);
        read_byte(8'h47, 1'b1);
        chk("rd_nack_release", 16'(sda_oe), 16'h0);
        i2c_stop();
        chk("rd_idx_after", 16'(reg_idx), 16'h7);
        chk("rd_busy_clr", 16'(busy), 16'h0);

        // Foreign address is NACKed; the next START to us is ACKed.
        i2c_start();
        write_byte(8'h54, 1'b1);
        chk("nack_busy", 16'(busy), 16'h0);
        i2c_start();
        write_byte(8'hAA, 1'b0);
        chk("readdr_busy", 16'(busy), 16'h1);
        i2c_stop();
        chk("readdr_busy_clr", 16'(busy), 16'h0);

        // Pointer wraps from 15 to 0.
        exp_wr.push_back({8'd15, 8'h5A});
        exp_wr.push_back({8'd0,  8'hC3});
        i2c_start();
        write_byte(8'hAA, 1'b0);
        write_byte(8'h0F, 1'b0);
        write_byte(8'h5A, 1'b0);
        write_byte(8'hC3, 1'b0);
        i2c_stop();
        chk("wrap_idx_after", 16'(reg_idx), 16'h1);

        // Out-of-range index is NACKed and the pointer is kept.
        i2c_start();
        write_byte(8'hAA, 1'b0);
        write_byte(8'h20, 1'b1);
        chk("badidx_keep", 16'(reg_idx), 16'h1);
        i2c_stop();
        chk("badidx_busy_clr", 16'(busy), 16'h0);

        // Reset during bit 4 of a read of regs[1] = 0x41 (bit 4 drives SDA low).
        i2c_start();
        write_byte(8'hAB, 1'b0);
        for (int i = 0; i < 3; i++) recv_bit(b);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        chk("rst_pre_drive", 16'(sda_oe), 16'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_sda_oe", 16'(sda_oe),  16'h0);
        chk("rst_mid_busy",   16'(busy),    16'h0);
        chk("rst_mid_idx",    16'(reg_idx), 16'h0);
        wq(3);
        reset_n = 1'b1;
        wq(Q);
        exp_wr.push_back({8'd7, 8'h99});
        i2c_start();
        write_byte(8'hAA, 1'b0);
        write_byte(8'h07, 1'b0);
        write_byte(8'h99, 1'b0);
        i2c_stop();
        chk("post_rst_idx", 16'(reg_idx), 16'h8);

        wq(10);
        while (exp_wr.size() > 0) begin
            total++; bad++;
            $display("FAIL wr_missing: got none expected %0h", exp_wr.pop_front());
        end
        while (exp_ack.size() > 0) begin
            total++; bad++;
            $display("FAIL ack_missing: got none expected %0b", exp_ack.pop_front());
        end
        while (exp_rd.size() > 0) begin
            total++; bad++;
            $display("FAIL rd_missing: got none expected %0h", exp_rd.pop_front());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 The module SHALL have parameter TARGET_ADDR, default 7'h55, meaning the 7-bit address it acknowledges.
REQ-002 The module SHALL have parameter NUM_REGS, default 16, range 2..256, meaning the number of 8-bit registers addressable through the register port.
REQ-003 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchroniser flops on SCL and SDA.
REQ-004 Port clk, input, 1 bit: system clock, at least 8x SCL frequency.
REQ-005 Port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 Port scl_i, input, 1 bit: bus clock, asynchronous to clk.
REQ-007 Port sda_i, input, 1 bit: bus data, asynchronous to clk.
REQ-008 Port sda_oe, output, 1 bit: 1 pulls SDA low; the pad is open-drain, external to this block.
REQ-009 Port wr_en, output, 1 bit: one-clk write strobe.
REQ-010 Port reg_idx, output, clog2(NUM_REGS) bits: register pointer, valid for both write and read.
REQ-011 Port wr_data, output, 8 bits: write data, valid while wr_en=1.
REQ-012 Port rd_data, input, 8 bits: contents of register reg_idx, combinational from the user side.
REQ-013 Port busy, output, 1 bit: high from an addressed START until STOP.

Function
REQ-014 SCL and SDA SHALL pass through SYNC_STAGES flops; all bus events SHALL be decoded from the synchronised signals.
REQ-015 START (SDA falling while SCL high) SHALL move the state machine to ADDR from any state, which also makes it a repeated START.
REQ-016 STOP (SDA rising while SCL high) SHALL return to IDLE from any state, releasing sda_oe and clearing busy.
REQ-017 SDA SHALL be sampled on synchronised SCL rising edges; sda_oe SHALL change only on synchronised SCL falling edges.
REQ-018 States: IDLE, ADDR, ADDR_ACK, IDX, IDX_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
REQ-019 ADDR SHALL shift 8 bits MSB-first; bits 7:1 are the address and bit 0 is R/W.
REQ-020 On address match, ADDR_ACK SHALL drive ACK for one SCL period and set busy; it then goes to IDX if R/W=0 or RDATA if R/W=1.
REQ-021 On address mismatch, the block SHALL NACK (sda_oe=0) and go to WAIT_STOP.
REQ-022 IDX SHALL receive 1 byte; a value < NUM_REGS loads reg_idx, ACKs, and goes to WDATA.
REQ-023 An IDX value >= NUM_REGS SHALL NACK, leave reg_idx unchanged, and go to WAIT_STOP.
REQ-024 Each WDATA byte SHALL assert wr_en for exactly one clk on the 8th SCL rising edge, with the current reg_idx, then ACK; reg_idx SHALL increment after the ACK.
REQ-025 RDATA SHALL load rd_data into the transmit shifter on the SCL falling edge that ends the ACK, and shift it out MSB-first with sda_oe = ~bit.
REQ-026 In RDATA_ACK, a master ACK SHALL increment reg_idx and send the next byte; a master NACK SHALL release SDA and go to WAIT_STOP.
REQ-027 reg_idx increment SHALL wrap from NUM_REGS-1 to 0.
REQ-028 reg_idx SHALL persist across transactions, so a read without an IDX phase starts at the last pointer.
REQ-029 If START and a data-bit edge are decoded in the same clk, START SHALL win.

Reset
REQ-030 reset_n low SHALL asynchronously force state=IDLE, sda_oe=0, wr_en=0, reg_idx=0, wr_data=0, busy=0, shifters=0, and synchronisers to 1 (idle bus).
REQ-031 Reset asserted mid-transfer SHALL release SDA within the same clk, without glitching low.
REQ-032 After reset deasserts, the block SHALL ignore the bus until the next START.

Structure
REQ-033 A shared package i2c_pkg SHALL hold the state enum, the ACK=1'b0 and NACK=1'b1 constants, and the R/W bit position.
REQ-034 A sub-module i2c_sync_edge SHALL implement the parameterised synchroniser plus rise/fall pulse outputs, instantiated once per line.

Verification
REQ-035 Bench scenario: START, 0xAA (0x55 write), 0x03, 0x11, 0x22, STOP -> ACK on all bytes; wr_en pulses at idx 3 with 0x11 and at idx 4 with 0x22; busy drops at STOP.
REQ-036 Bench scenario: START, 0xAA, 0x05, repeated START, 0xAB, read 3 bytes with ACK, ACK, NACK, STOP -> bytes from idx 5, 6, 7; SDA released after the NACK.
REQ-037 Bench scenario: START, 0x54 (address 0x2A) -> NACK; no wr_en; busy stays 0; the next START with 0xAA is ACKed.
REQ-038 Bench scenario: NUM_REGS=16, write idx 0x0F then 2 bytes -> writes at idx 15 then idx 0 (wrap).
REQ-039 Bench scenario: idx byte 0x20 with NUM_REGS=16 -> NACK; reg_idx unchanged.
REQ-040 Bench scenario: reset_n pulsed low during bit 4 of a read byte -> sda_oe=0 immediately; a subsequent full write succeeds.
